// File: rtl/irq_ctrl.sv
`default_nettype none

`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

// ============================================================================
// Module      : irq_ctrl
// Description : Platform-level interrupt controller. Each source has its own
//               gateway FSM. Register access handles claim and complete.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl #(
    parameter int NSRC = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NSRC-1:0]       src,
    input  logic                  reg_valid,
    input  logic                  reg_write,
    input  logic [3:0]            reg_addr,
    input  logic [`DATA_SIZE-1:0] reg_wdata,
    output logic [`DATA_SIZE-1:0] reg_rdata,
    output logic                  reg_rvalid,
    output logic                  interrupt
);

    localparam logic [3:0] c_ADDR_PENDING = 4'h0;
    localparam logic [3:0] c_ADDR_ENABLE  = 4'h4;
    localparam logic [3:0] c_ADDR_TRIGGER = 4'h8;
    localparam logic [3:0] c_ADDR_CLAIM   = 4'hC;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_PEND    = 2'd1;
    localparam logic [1:0] c_ST_CLAIMED = 2'd2;

    logic [NSRC-1:0]       r_src_q;
    logic [NSRC-1:0]       r_enable;
    logic [NSRC-1:0]       r_trigger;
    logic [`DATA_SIZE-1:0] r_rdata;
    logic                  r_rvalid;
    logic                  r_interrupt;

    logic                  w_rd;
    logic                  w_wr;
    logic                  w_claim;
    logic                  w_complete;
    logic [NSRC-1:0]       w_fire;
    logic [NSRC-1:0]       w_pend;
    logic [NSRC-1:0]       w_cand;
    logic [NSRC-1:0]       w_grant;
    logic [4:0]            w_claim_id;
    logic [`DATA_SIZE-1:0] w_rdata_mux;
    logic                  w_unused;

    assign w_rd       = reg_valid & ~reg_write;
    assign w_wr       = reg_valid &  reg_write;
    assign w_claim    = w_rd & (reg_addr == c_ADDR_CLAIM);
    assign w_complete = w_wr & (reg_addr == c_ADDR_CLAIM);

    // Edge sources fire on a rising sample, level sources whenever high.
    assign w_fire = (r_trigger & src & ~r_src_q) | (~r_trigger & src);
    assign w_cand = w_pend & r_enable;

    // Only the upper write-data bits beyond both the id and NSRC are unused.
    assign w_unused = &{1'b0, reg_wdata};

    // Lowest id wins: scanning downward lets the lowest candidate land last.
    always_comb begin
        w_grant    = '0;
        w_claim_id = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_grant    = '0;
                w_grant[i] = 1'b1;
                w_claim_id = 5'(i + 1);
            end
        end
    end

    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
        localparam logic [4:0] c_ID = 5'(gi + 1);

        logic [1:0] r_state;
        logic [1:0] w_state_nxt;

        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                c_ST_IDLE:    if (w_fire[gi]) w_state_nxt = c_ST_PEND;
                c_ST_PEND:    if (w_claim && w_grant[gi]) w_state_nxt = c_ST_CLAIMED;
                c_ST_CLAIMED: if (w_complete && (reg_wdata[4:0] == c_ID)) w_state_nxt = c_ST_IDLE;
                default:      w_state_nxt = c_ST_IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= c_ST_IDLE;
            end else begin
                r_state <= w_state_nxt;
            end
        end

        assign w_pend[gi] = (r_state == c_ST_PEND);
    end

    always_comb begin
        w_rdata_mux = '0;
        case (reg_addr)
            c_ADDR_PENDING: w_rdata_mux[NSRC-1:0] = w_pend;
            c_ADDR_ENABLE:  w_rdata_mux[NSRC-1:0] = r_enable;
            c_ADDR_TRIGGER: w_rdata_mux[NSRC-1:0] = r_trigger;
            c_ADDR_CLAIM:   w_rdata_mux[4:0]      = w_claim_id;
            default:        w_rdata_mux           = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_src_q     <= '0;
            r_enable    <= '0;
            r_trigger   <= '0;
            r_rdata     <= '0;
            r_rvalid    <= 1'b0;
            r_interrupt <= 1'b0;
        end else begin
            r_src_q <= src;
            if (w_wr && (reg_addr == c_ADDR_ENABLE)) begin
                r_enable <= reg_wdata[NSRC-1:0];
            end
            if (w_wr && (reg_addr == c_ADDR_TRIGGER)) begin
                r_trigger <= reg_wdata[NSRC-1:0];
            end
            r_rvalid <= w_rd;
            if (w_rd) begin
                r_rdata <= w_rdata_mux;
            end
            r_interrupt <= |w_cand;
        end
    end

    assign reg_rdata  = r_rdata;
    assign reg_rvalid = r_rvalid;
    assign interrupt  = r_interrupt;

endmodule

`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none

// ============================================================================
// Module      : tb_irq_ctrl
// Description : Self-checking bench for irq_ctrl against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;

    localparam int NSRC = 8;
    localparam int M_IDLE = 0;
    localparam int M_PEND = 1;
    localparam int M_CLAIMED = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NSRC-1:0] src = '0;
    logic            reg_valid = 1'b0;
    logic            reg_write = 1'b0;
    logic [3:0]      reg_addr = '0;
    logic [31:0]     reg_wdata = '0;
    logic [31:0]     reg_rdata;
    logic            reg_rvalid;
    logic            interrupt;

    int checks = 0;
    int errors = 0;

    int              m_state [NSRC];
    logic [NSRC-1:0] m_en = '0;
    logic [NSRC-1:0] m_trig = '0;
    logic [NSRC-1:0] m_prev = '0;
    logic            m_irq = 1'b0;
    logic            m_rvalid = 1'b0;
    logic [31:0]     m_rdata = '0;

    irq_ctrl #(.NSRC(NSRC)) dut (
        .clk       (clk),
        .rst       (rst),
        .src       (src),
        .reg_valid (reg_valid),
        .reg_write (reg_write),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .reg_rvalid(reg_rvalid),
        .interrupt (interrupt)
    );

    always #5 clk = ~clk;

    // Advance one clock; the model consumes the same inputs the DUT sees.
    task automatic tick();
        int              nst [NSRC];
        logic [NSRC-1:0] fire;
        logic [NSRC-1:0] pend;
        int              pick;
        logic [31:0]     rv;
        logic            rd;
        logic            wr;
        logic [NSRC-1:0] nen;
        logic [NSRC-1:0] ntrig;
        logic            nirq;
        for (int i = 0; i < NSRC; i++) begin
            fire[i] = m_trig[i] ? (src[i] && !m_prev[i]) : src[i];
            pend[i] = (m_state[i] == M_PEND);
        end
        pick = 0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (pend[i] && m_en[i]) pick = i + 1;
        nirq = |(pend & m_en);
        rd = reg_valid && !reg_write;
        wr = reg_valid && reg_write;
        case (reg_addr)
            4'h0:    rv = 32'(pend);
            4'h4:    rv = 32'(m_en);
            4'h8:    rv = 32'(m_trig);
            4'hC:    rv = 32'(pick);
            default: rv = 32'd0;
        endcase
        for (int i = 0; i < NSRC; i++) begin
            nst[i] = m_state[i];
            if (m_state[i] == M_IDLE && fire[i]) nst[i] = M_PEND;
            if (m_state[i] == M_PEND && rd && reg_addr == 4'hC && pick == i + 1) nst[i] = M_CLAIMED;
            if (m_state[i] == M_CLAIMED && wr && reg_addr == 4'hC && int'(reg_wdata[4:0]) == i + 1)
                nst[i] = M_IDLE;
        end
        nen   = (wr && reg_addr == 4'h4) ? reg_wdata[NSRC-1:0] : m_en;
        ntrig = (wr && reg_addr == 4'h8) ? reg_wdata[NSRC-1:0] : m_trig;
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < NSRC; i++) m_state[i] = M_IDLE;
            m_en = '0; m_trig = '0; m_prev = '0;
            m_irq = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        end else begin
            for (int i = 0; i < NSRC; i++) m_state[i] = nst[i];
            m_en = nen; m_trig = ntrig; m_prev = src;
            m_irq = nirq; m_rvalid = rd;
            if (rd) m_rdata = rv;
        end
    endtask

    task automatic bus_idle();
        reg_valid = 1'b0; reg_write = 1'b0; reg_addr = '0; reg_wdata = '0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        reg_valid = 1'b1; reg_write = 1'b1; reg_addr = a; reg_wdata = d;
        tick();
        bus_idle();
    endtask

    task automatic do_read(input logic [3:0] a);
        reg_valid = 1'b1; reg_write = 1'b0; reg_addr = a; reg_wdata = '0;
        tick();
        bus_idle();
    endtask

    task automatic do_reset();
        rst = 1'b1; src = '0; bus_idle();
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (interrupt !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", interrupt); end
        checks++;
        if (reg_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", reg_rvalid); end
        checks++;
        if (reg_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", reg_rdata); end
        do_read(4'h4);
        checks++;
        if (reg_rdata !== 32'd0 || reg_rvalid !== 1'b1) begin
            errors++; $display("FAIL reset_enable: got %h/%b want 0/1", reg_rdata, reg_rvalid);
        end
        do_read(4'h8);
        checks++;
        if (reg_rdata !== 32'd0) begin errors++; $display("FAIL reset_trigger: got %h want 0", reg_rdata); end
    endtask

    task automatic test_level_claim();
        bit seen;
        do_reset();
        do_write(4'h4, 32'h04);
        src = 8'h04;
        seen = 0;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (interrupt === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || m_irq !== 1'b1) begin errors++; $display("FAIL level_irq_rise: got %b want 1", interrupt); end
        do_read(4'hC);
        checks++;
        if (reg_rvalid !== 1'b1 || reg_rdata !== 32'd3 || reg_rdata !== m_rdata) begin
            errors++; $display("FAIL level_claim: got %h/%b want 3/1", reg_rdata, reg_rvalid);
        end
        tick();
        checks++;
        if (interrupt !== 1'b0) begin errors++; $display("FAIL level_irq_drop: got %b want 0", interrupt); end
        do_write(4'hC, 32'd3);
        tick();
        do_read(4'h0);
        checks++;
        if (reg_rdata !== 32'h4 || reg_rdata !== m_rdata) begin
            errors++; $display("FAIL level_repend: got %h want 4", reg_rdata);
        end
        checks++;
        if (interrupt !== 1'b1) begin errors++; $display("FAIL level_irq_again: got %b want 1", interrupt); end
        src = '0;
    endtask

    task automatic test_edge();
        do_reset();
        do_write(4'h8, 32'h01);
        do_write(4'h4, 32'h01);
        src = 8'h01; tick(); src = '0; tick();
        do_read(4'h0);
        checks++;
        if (reg_rdata !== 32'h1) begin errors++; $display("FAIL edge_pend: got %h want 1", reg_rdata); end
        do_read(4'hC);
        checks++;
        if (reg_rdata !== 32'd1) begin errors++; $display("FAIL edge_claim: got %h want 1", reg_rdata); end
        src = 8'h01; tick(); src = '0; tick();
        do_write(4'hC, 32'd1);
        tick();
        do_read(4'h0);
        checks++;
        if (reg_rdata !== 32'h0 || reg_rdata !== m_rdata) begin
            errors++; $display("FAIL edge_dropped: got %h want 0", reg_rdata);
        end
    endtask

    task automatic test_priority();
        logic [31:0] want [3];
        want[0] = 32'd2; want[1] = 32'd6; want[2] = 32'd0;
        do_reset();
        do_write(4'h4, 32'hFF);
        src = 8'h22; tick(); src = '0; tick();
        for (int k = 0; k < 3; k++) begin
            do_read(4'hC);
            checks++;
            if (reg_rdata !== want[k] || reg_rdata !== m_rdata) begin
                errors++; $display("FAIL priority_claim%0d: got %h want %h", k, reg_rdata, want[k]);
            end
        end
    endtask

    task automatic test_mask();
        do_reset();
        src = 8'h08; tick(); src = '0; tick(); tick();
        checks++;
        if (interrupt !== 1'b0) begin errors++; $display("FAIL mask_irq_off: got %b want 0", interrupt); end
        do_read(4'hC);
        checks++;
        if (reg_rdata !== 32'd0) begin errors++; $display("FAIL mask_claim_none: got %h want 0", reg_rdata); end
        do_write(4'h4, 32'h08);
        tick();
        checks++;
        if (interrupt !== 1'b1) begin errors++; $display("FAIL mask_irq_on: got %b want 1", interrupt); end
        do_read(4'hC);
        checks++;
        if (reg_rdata !== 32'd4) begin errors++; $display("FAIL mask_claim: got %h want 4", reg_rdata); end
    endtask

    task automatic test_bad_complete();
        src = 8'h02; tick(); src = '0; tick();
        do_write(4'hC, 32'd9);
        do_write(4'hC, 32'd2);
        do_read(4'h0);
        checks++;
        if (reg_rdata !== 32'h2 || reg_rdata !== m_rdata) begin
            errors++; $display("FAIL bad_complete: got %h want 2", reg_rdata);
        end
        do_read(4'h5);
        checks++;
        if (reg_rdata !== 32'd0 || reg_rvalid !== 1'b1) begin
            errors++; $display("FAIL undecoded_read: got %h/%b want 0/1", reg_rdata, reg_rvalid);
        end
    endtask

    task automatic test_reset_mid_claim();
        do_reset();
        do_write(4'h4, 32'h10);
        src = 8'h10; tick(); src = '0; tick(); tick();
        rst = 1'b1; reg_valid = 1'b1; reg_write = 1'b0; reg_addr = 4'hC;
        tick();
        rst = 1'b0; bus_idle();
        checks++;
        if (reg_rvalid !== 1'b0 || interrupt !== 1'b0) begin
            errors++; $display("FAIL rst_claim_out: got rvalid %b irq %b want 0 0", reg_rvalid, interrupt);
        end
        tick();
        do_read(4'h0);
        checks++;
        if (reg_rdata !== 32'd0) begin errors++; $display("FAIL rst_claim_pend: got %h want 0", reg_rdata); end
        do_read(4'h4);
        checks++;
        if (reg_rdata !== 32'd0) begin errors++; $display("FAIL rst_claim_enable: got %h want 0", reg_rdata); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            src = NSRC'($urandom & $urandom);
            rst = ($urandom_range(0, 99) == 0);
            reg_valid = $urandom_range(0, 1);
            reg_write = $urandom_range(0, 1);
            case ($urandom_range(0, 5))
                0:       reg_addr = 4'h0;
                1:       reg_addr = 4'h4;
                2:       reg_addr = 4'h8;
                3, 4:    reg_addr = 4'hC;
                default: reg_addr = 4'($urandom);
            endcase
            reg_wdata = (reg_addr == 4'hC) ? 32'($urandom_range(0, 10)) : $urandom;
            tick();
            checks++;
            if (interrupt !== m_irq) begin errors++; $display("FAIL rnd_irq@%0d: got %b want %b", n, interrupt, m_irq); end
            checks++;
            if (reg_rvalid !== m_rvalid) begin
                errors++; $display("FAIL rnd_rvalid@%0d: got %b want %b", n, reg_rvalid, m_rvalid);
            end
            checks++;
            if (reg_rdata !== m_rdata) begin
                errors++; $display("FAIL rnd_rdata@%0d: got %h want %h", n, reg_rdata, m_rdata);
            end
        end
        rst = 1'b0; src = '0; bus_idle();
    endtask

    initial begin
        for (int i = 0; i < NSRC; i++) m_state[i] = M_IDLE;
        test_reset();
        test_level_claim();
        test_edge();
        test_priority();
        test_mask();
        test_bad_complete();
        test_reset_mid_claim();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter SHALL be NSRC, default 8, number of external interrupt sources (1..31); source index i has id i+1, and id 0 means "none".
REQ-002 Port SHALL be clk, input, 1, the single clock; all logic on posedge.
REQ-003 Port SHALL be rst, input, 1, synchronous active-high reset.
REQ-004 Port SHALL be src, input, NSRC, raw interrupt request lines, already synchronous to clk.
REQ-005 Port SHALL be reg_valid, input, 1, register access strobe, one access per cycle.
REQ-006 Port SHALL be reg_write, input, 1; 1 means write and 0 means read, qualified by reg_valid.
REQ-007 Port SHALL be reg_addr, input, 4, byte offset; only 0x0, 0x4, 0x8 and 0xC are decoded.
REQ-008 Port SHALL be reg_wdata, input, `data_size (32), write data.
REQ-009 Port SHALL be reg_rdata, output, `data_size, read data, registered.
REQ-010 Port SHALL be reg_rvalid, output, 1, high for one cycle, 1 cycle after a read access.
REQ-011 Port SHALL be interrupt, output, 1, machine external interrupt level to the core CSR mip[11], registered.

Function
REQ-012 Each source SHALL own a 3-state gateway FSM: IDLE, PEND, CLAIMED.
REQ-013 TRIGGER bit i SHALL select the mode of source i: 1 = edge, 0 = level.
- Edge: fires on src[i]=1 with the previous-cycle sample 0.
- Level: fires whenever src[i]=1.
REQ-014 IDLE SHALL go to PEND on a fire; a fire while in PEND or CLAIMED SHALL be dropped, not queued.
REQ-015 PEND SHALL go to CLAIMED when a claim read selects that source.
REQ-016 CLAIMED SHALL go to IDLE on a complete write whose id matches; a level source still high re-enters PEND on the following cycle.
REQ-017 Register map:
- 0x0 PENDING: RO, bit i = FSM in PEND.
- 0x4 ENABLE: RW, NSRC bits.
- 0x8 TRIGGER: RW, NSRC bits.
- 0xC CLAIM/COMPLETE: read = claim, write = complete with id in reg_wdata[4:0].
REQ-018 Claim read SHALL return the lowest id whose source is in PEND with ENABLE set, and move only that source to CLAIMED; with no candidate it SHALL return 0 and change no state.
REQ-019 Claim arbitration SHALL use the FSM state before the access cycle; a source firing in the same cycle is not eligible.
REQ-020 A complete write with id 0, id > NSRC, or id not in CLAIMED SHALL be ignored without error.
REQ-021 interrupt SHALL be registered as |(PEND & ENABLE) computed on current-cycle state, i.e. 1 cycle after a source enters PEND.
REQ-022 Clearing an ENABLE bit while its source is in PEND SHALL leave it in PEND, unclaimable, and excluded from interrupt; re-enabling makes it eligible again.
REQ-023 Reads of undecoded offsets SHALL return 0; writes to undecoded offsets and to PENDING SHALL be ignored; upper unused bits SHALL read 0.
REQ-024 reg_rdata SHALL hold its last value when reg_rvalid is 0.
REQ-025 A write to TRIGGER SHALL not alter current FSM states.

Reset
REQ-026 On rst: all FSMs go to IDLE; ENABLE = 0; TRIGGER = 0 (level); the edge-sample register = 0; interrupt = 0; reg_rdata = 0; reg_rvalid = 0.
REQ-027 rst SHALL override any same-cycle register access, including discarding a claim in flight.

Verification
REQ-028 Level claim/complete: ENABLE=0x04, src[2] held high → interrupt=1 within 2 cycles; read 0xC → rdata=3 and interrupt=0 next cycle; write 0xC=3 with src still high → PENDING bit2=1 again, interrupt=1.
REQ-029 Edge mode: TRIGGER=0x01, ENABLE=0x01, 1-cycle pulse on src[0] → PENDING=0x1; a second pulse while CLAIMED is dropped, so after complete(1) PENDING=0.
REQ-030 Priority: src[1] and src[5] pend together, ENABLE=0xFF → first claim returns 2, second claim returns 6, third claim returns 0.
REQ-031 Masking: src[3] pending with ENABLE=0 → interrupt=0 and claim returns 0; set ENABLE=0x08 → interrupt=1, and claim returns 4.
REQ-032 Bad complete: write 0xC=9, then write 0xC=2 while source 2 is not CLAIMED → no state change; reading offset 0x5 returns 0.
REQ-033 Reset mid-claim: assert rst in the same cycle as a claim read → reg_rvalid=0, all PENDING=0, ENABLE=0, interrupt=0.
